spmv_row_sched: RTL and testbench

Sequencer for the HHT sparse matrix-vector datapath. Walks a CSR matrix row by row, drives the two combinational-read memory ports (index memory for row pointers and column indices, value memory for matrix and vector values), and emits one {row, matrix value, vector value} element per nonzero to the downstream multiply-accumulate stage under a valid/ready handshake. It sits between the memories and the MAC and replaces ad-hoc address sequencing in `control`.

---
 rtl/spmv_row_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_spmv_row_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_sched.sv
// spmv_row_sched
// --------------
// Walks a CSR sparse matrix row by row and streams one {row, matrix value,
// vector value} element per nonzero to the downstream multiply-accumulate
// stage. Both memory ports are combinational-read: read data is valid in the
// same cycle the address is driven.
//
// Ports:
//   Clk, Rst          clock; synchronous active-high reset
//   start             one-cycle pass request, sampled only while idle
//   num_rows          rows in the pass, captured on accepted start
//   row_base          base address of the row-pointer array (index memory)
//   wdata_col_base    base address of the column-index array (index memory)
//   matrix_base       base address of the matrix-value array (value memory)
//   v_values_base     base address of the dense vector (value memory)
//   addr1 / dataIn1   index-memory address / read data
//   addr2 / dataIn2   value-memory address / read data
//   elem_valid/ready  element handshake towards the MAC
//   elem_row/mat/vec  element payload (qualified by elem_valid)
//   elem_last         element is the last nonzero of its row
//   row_done          one-cycle pulse at the end of every row, empty or not
//   busy              high whenever not idle
//   done              one-cycle pulse when the pass completes
module spmv_row_sched #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RW = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [RW-1:0] num_rows,
    input  logic [AW-1:0] row_base,
    input  logic [AW-1:0] wdata_col_base,
    input  logic [AW-1:0] matrix_base,
    input  logic [AW-1:0] v_values_base,
    output logic [AW-1:0] addr1,
    input  logic [DW-1:0] dataIn1,
    output logic [AW-1:0] addr2,
    input  logic [DW-1:0] dataIn2,
    output logic          elem_valid,
    input  logic          elem_ready,
    output logic [RW-1:0] elem_row,
    output logic [DW-1:0] elem_mat,
    output logic [DW-1:0] elem_vec,
    output logic          elem_last,
    output logic          row_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR0,
        S_PTR,
        S_IDX,
        S_VEC,
        S_EMIT,
        S_ROWEND,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [DW-1:0] k_q, k_d;
    logic [DW-1:0] kend_q, kend_d;
    logic [DW-1:0] col_q, col_d;
    logic [DW-1:0] mat_q, mat_d;
    logic [DW-1:0] vec_q, vec_d;
    logic [RW-1:0] num_rows_q, num_rows_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] col_base_q, col_base_d;
    logic [AW-1:0] mat_base_q, mat_base_d;
    logic [AW-1:0] vec_base_q, vec_base_d;

    logic [DW-1:0] k_inc;
    logic [RW-1:0] r_inc;

    assign k_inc = k_q + DW'(1);
    assign r_inc = r_q + RW'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: every register here is a plain flop (no memory array), so all of
    // them are cleared on reset; that keeps elem_row/mat/vec at 0 afterwards.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            k_q        <= '0;
            kend_q     <= '0;
            col_q      <= '0;
            mat_q      <= '0;
            vec_q      <= '0;
            num_rows_q <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            mat_base_q <= '0;
            vec_base_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            r_q        <= r_d;
            k_q        <= k_d;
            kend_q     <= kend_d;
            col_q      <= col_d;
            mat_q      <= mat_d;
            vec_q      <= vec_d;
            num_rows_q <= num_rows_d;
            row_base_q <= row_base_d;
            col_base_q <= col_base_d;
            mat_base_q <= mat_base_d;
            vec_base_q <= vec_base_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: hold-value defaults first, so no path leaves a signal
        // unassigned and no latch is inferred.
        state_d    = state_q;
        r_d        = r_q;
        k_d        = k_q;
        kend_d     = kend_q;
        col_d      = col_q;
        mat_d      = mat_q;
        vec_d      = vec_q;
        num_rows_d = num_rows_q;
        row_base_d = row_base_q;
        col_base_d = col_base_q;
        mat_base_d = mat_base_q;
        vec_base_d = vec_base_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_rows_d = num_rows;
                    row_base_d = row_base;
                    col_base_d = wdata_col_base;
                    mat_base_d = matrix_base;
                    vec_base_d = v_values_base;
                    r_d        = '0;
                    state_d    = (num_rows == '0) ? S_DONE : S_PTR0;
                end
            end
            S_PTR0: begin
                // row_ptr[0]: start pointer of the first row
                k_d     = dataIn1;
                state_d = S_PTR;
            end
            S_PTR: begin
                // row_ptr[r+1]; an end at or below the start is treated as empty
                kend_d  = dataIn1;
                state_d = (dataIn1 <= k_q) ? S_ROWEND : S_IDX;
            end
            S_IDX: begin
                col_d   = dataIn1;
                mat_d   = dataIn2;
                state_d = S_VEC;
            end
            S_VEC: begin
                vec_d   = dataIn2;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (elem_ready) begin
                    k_d     = k_inc;
                    state_d = (k_inc < kend_q) ? S_IDX : S_ROWEND;
                end
            end
            S_ROWEND: begin
                // This row's end is the next row's start, so it is not re-read.
                k_d = kend_q;
                if (r_inc == num_rows_q) begin
                    state_d = S_DONE;
                end else begin
                    r_d     = r_inc;
                    state_d = S_PTR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        addr1      = '0;
        addr2      = '0;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
        row_done   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_PTR0: begin
                addr1 = row_base_q;
            end
            S_PTR: begin
                addr1 = row_base_q + AW'(r_q) + AW'(1);
            end
            S_IDX: begin
                addr1 = col_base_q + AW'(k_q);
                addr2 = mat_base_q + AW'(k_q);
            end
            S_VEC: begin
                addr2 = vec_base_q + AW'(col_q);
            end
            S_EMIT: begin
                elem_valid = 1'b1;
                elem_last  = (k_inc == kend_q);
            end
            S_ROWEND: begin
                row_done = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign elem_row = r_q;
    assign elem_mat = mat_q;
    assign elem_vec = vec_q;

endmodule

// File: tb/tb_spmv_row_sched.sv
// Testbench for spmv_row_sched: a 16-row CSR image in two behavioural
// combinational-read memories; expected elements are queued when a pass is
// launched and a monitor pops and compares them at every handshake.
module tb_spmv_row_sched;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 16;

    localparam int ROW_BASE = 0;
    localparam int COL_BASE = 32;
    localparam int MAT_BASE = 90;
    localparam int VEC_BASE = 2;
    localparam int NROWS    = 16;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [DW-1:0] mat;
        logic [DW-1:0] vec;
        logic          last;
    } elem_t;

    // CSR image
    int row_ptr [17] = '{0, 1, 4, 5, 6, 8, 10, 13, 17, 19, 19, 20, 22, 23, 23, 24, 25};
    int col_idx [26] = '{0, 1, 4, 5, 6, 8, 10, 13, 17, 19, 19, 20, 22, 23, 23, 24, 25,
                         7, 9, 11, 15, 11, 14, 2, 10, 14};
    int mat_v   [25] = '{91, 37, 69, 14, 73, 22, 58, 66, 19, 80, 33, 47, 95, 11, 62,
                         28, 54, 77, 39, 85, 16, 43, 99, 26, 71};
    int vec_v   [26] = '{46, 51, 5, 87, 28, 63, 12, 90, 34, 57, 8, 75, 41, 68, 23,
                         96, 17, 52, 81, 30, 64, 9, 45, 72, 38, 13};

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic [RW-1:0] num_rows;
    logic [AW-1:0] row_base, wdata_col_base, matrix_base, v_values_base;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] dataIn1, dataIn2;
    logic          elem_valid, elem_ready, elem_last, row_done, busy, done;
    logic [RW-1:0] elem_row;
    logic [DW-1:0] elem_mat, elem_vec;

    logic [DW-1:0] imem [256];
    logic [DW-1:0] vmem [256];

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    elem_count = 0;
    int    rowdone_count = 0;
    int    rd_cyc [NROWS];
    elem_t got [3];
    elem_t exp_q [$];
    bit    rand_ready = 1'b0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    assign dataIn1 = (addr1 < AW'(256)) ? imem[addr1[7:0]] : '0;
    assign dataIn2 = (addr2 < AW'(256)) ? vmem[addr2[7:0]] : '0;

    spmv_row_sched #(.AW(AW), .DW(DW), .RW(RW)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .start          (start),
        .num_rows       (num_rows),
        .row_base       (row_base),
        .wdata_col_base (wdata_col_base),
        .matrix_base    (matrix_base),
        .v_values_base  (v_values_base),
        .addr1          (addr1),
        .dataIn1        (dataIn1),
        .addr2          (addr2),
        .dataIn2        (dataIn2),
        .elem_valid     (elem_valid),
        .elem_ready     (elem_ready),
        .elem_row       (elem_row),
        .elem_mat       (elem_mat),
        .elem_vec       (elem_vec),
        .elem_last      (elem_last),
        .row_done       (row_done),
        .busy           (busy),
        .done           (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // elem_ready changes just after each rising edge, stable at the sample point
    initial begin
        elem_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            elem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, row_done stamps and stall stability
    initial begin
        bit    stall_prev;
        elem_t prev;
        elem_t cur;
        elem_t e;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge Clk);
            cur = '{row: elem_row, mat: elem_mat, vec: elem_vec, last: elem_last};
            if (Rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", elem_valid, 1'b1);
                    check("stall_payload_held", cur, prev);
                end
                if (elem_valid && elem_ready) begin
                    check("elem_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("elem_row", cur.row, e.row);
                        check("elem_mat", cur.mat, e.mat);
                        check("elem_vec", cur.vec, e.vec);
                        check("elem_last", cur.last, e.last);
                    end
                    if (elem_count < 3) got[elem_count] = cur;
                    elem_count++;
                end
                if (row_done) begin
                    if (elem_row < RW'(NROWS)) rd_cyc[elem_row] = cyc;
                    rowdone_count++;
                end
                stall_prev = elem_valid && !elem_ready;
                prev = cur;
            end
        end
    end

    task automatic push_pass(input int nrows, output int total);
        elem_t e;
        total = 0;
        for (int r = 0; r < nrows; r++) begin
            for (int k = row_ptr[r]; k < row_ptr[r+1]; k++) begin
                e.row  = RW'(r);
                e.mat  = DW'(mat_v[k]);
                e.vec  = DW'(vec_v[col_idx[k]]);
                e.last = (k + 1 == row_ptr[r+1]);
                exp_q.push_back(e);
                total++;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr1"}, addr1, 0);
        check({tag, "_addr2"}, addr2, 0);
        check({tag, "_elem_valid"}, elem_valid, 0);
        check({tag, "_elem_row"}, elem_row, 0);
        check({tag, "_elem_mat"}, elem_mat, 0);
        check({tag, "_elem_vec"}, elem_vec, 0);
        check({tag, "_elem_last"}, elem_last, 0);
        check({tag, "_row_done"}, row_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic check_first_three(input string tag);
        check({tag, "_e0"}, got[0], {16'd0, 32'd91, 32'd46, 1'b1});
        check({tag, "_e1"}, got[1], {16'd1, 32'd37, 32'd51, 1'b0});
        check({tag, "_e2"}, got[2], {16'd1, 32'd69, 32'd28, 1'b0});
    endtask

    // One pass of nrows rows. fixed_timing enables cycle-exact checks
    // (elem_ready held high); poke_start fires start and changes num_rows
    // while the pass is in flight.
    task automatic run_pass(input int nrows, input bit fixed_timing, input bit poke_start);
        int total, t_s, t_d, prev_t;
        push_pass(nrows, total);
        rand_ready = !fixed_timing;
        @(negedge Clk);
        elem_count = 0;
        rowdone_count = 0;
        start = 1'b1;
        num_rows = RW'(nrows);
        t_s = cyc + 1;  // index of the edge that samples start
        @(negedge Clk);
        start = 1'b0;
        t_d = 0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                t_d = cyc;
                break;
            end
            if (poke_start) begin
                start = (i == 10 || i == 40 || i == 77);
                num_rows = RW'(3);
            end
            @(negedge Clk);
        end
        start = 1'b0;
        num_rows = RW'(nrows);
        check("done_seen", done, 1'b1);
        check("elem_count", elem_count, total);
        check("row_done_count", rowdone_count, nrows);
        check("queue_drained", exp_q.size(), 0);
        if (fixed_timing) begin
            check("done_latency", t_d - t_s, 108);
            prev_t = t_s;
            for (int r = 0; r < nrows; r++) begin
                check("row_cycles", rd_cyc[r] - prev_t, 3 * (row_ptr[r+1] - row_ptr[r]) + 2);
                prev_t = rd_cyc[r];
            end
            check("row9_empty_cycles", rd_cyc[9] - rd_cyc[8], 2);
        end
        @(negedge Clk);
        check("busy_after_done", busy, 1'b0);
        check("done_single_pulse", done, 1'b0);
        rand_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            vmem[i] = '0;
        end
        for (int i = 0; i < 17; i++) imem[ROW_BASE + i] = DW'(row_ptr[i]);
        for (int i = 0; i < 26; i++) imem[COL_BASE + i] = DW'(col_idx[i]);
        for (int i = 0; i < 25; i++) vmem[MAT_BASE + i] = DW'(mat_v[i]);
        for (int i = 0; i < 26; i++) vmem[VEC_BASE + i] = DW'(vec_v[i]);

        Rst            = 1'b1;
        start          = 1'b0;
        num_rows       = '0;
        row_base       = AW'(ROW_BASE);
        wdata_col_base = AW'(COL_BASE);
        matrix_base    = AW'(MAT_BASE);
        v_values_base  = AW'(VEC_BASE);

        // Reset state
        repeat (3) @(negedge Clk);
        check_zero("reset");
        Rst = 1'b0;

        // Full pass, elem_ready held high
        run_pass(NROWS, 1'b1, 1'b0);
        check_first_three("pass1");

        // Same image with random back-pressure
        run_pass(NROWS, 1'b0, 1'b0);
        check_first_three("pass_bp");

        // num_rows = 0: one DONE cycle, no addresses, no elements
        @(negedge Clk);
        elem_count = 0;
        rowdone_count = 0;
        start = 1'b1;
        num_rows = '0;
        @(negedge Clk);
        start = 1'b0;
        check("zero_busy", busy, 1'b1);
        check("zero_done", done, 1'b1);
        check("zero_addr1", addr1, 0);
        check("zero_addr2", addr2, 0);
        check("zero_valid", elem_valid, 1'b0);
        @(negedge Clk);
        check("zero_busy_after", busy, 1'b0);
        check("zero_done_after", done, 1'b0);
        check("zero_elems", elem_count, 0);
        check("zero_row_done", rowdone_count, 0);

        // Reset during EMIT of row 3
        begin
            int total;
            push_pass(NROWS, total);
            @(negedge Clk);
            start = 1'b1;
            num_rows = RW'(NROWS);
            @(negedge Clk);
            start = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (elem_valid && elem_row == RW'(3)) break;
                @(negedge Clk);
            end
            check("reached_row3_emit", elem_valid && elem_row == RW'(3), 1'b1);
            Rst = 1'b1;
            @(negedge Clk);
            check_zero("midreset");
            Rst = 1'b0;
            exp_q.delete();
        end
        run_pass(NROWS, 1'b1, 1'b0);
        check_first_three("after_reset");

        // start pulsed and num_rows changed while busy: no effect
        run_pass(NROWS, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
